jk_drive_sequencer: RTL and testbench
=====================================

Name: jk_drive_sequencer

Overview:
- Upstream command stage for a bank of WIDTH JK flip-flops (one JK_flipflop per bit).
- Accepts hold/clear/set/toggle commands with a per-bit mask and a repeat count over a valid/ready handshake, and buffers them in a DEPTH-entry FIFO.
- Replays each command for the requested number of cycles as registered J/K vectors, one bit pair per flop.
- Downstream flops see clean, glitch-free J/K values that are stable for a whole clock period.

Parameters:
- WIDTH, 8, number of JK flops driven (width of mask, j_out, k_out).
- DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.
- CNT_W, 4, width of the repeat field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  2  00 hold, 01 clear (J=0 K=1), 10 set (J=1 K=0), 11 toggle (J=1 K=1).
- cmd_mask  input  WIDTH  bits affected by the command; unmasked bits get J=0 K=0.
- cmd_repeat  input  CNT_W  number of issue cycles; 0 is treated as 1.
- j_out  output  WIDTH  registered J vector to the flop bank.
- k_out  output  WIDTH  registered K vector to the flop bank.
- busy  output  1  FSM is in ISSUE.
- fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset state:
  - FIFO is emptied: fifo_count=0 and cmd_ready=1 on the cycle after reset.
  - FSM goes to IDLE, busy=0, j_out=0, k_out=0.
  - The repeat counter is cleared.
  - Reset asserted mid-command aborts the command immediately; no further J/K pulses are issued.
- Handshake:
  - cmd_ready = (fifo_count < DEPTH); it is combinational from registered count.
  - A push happens at an edge where cmd_valid && cmd_ready.
  - When full, cmd_ready=0 even if a pop occurs the same cycle; there is no pass-through.
  - While cmd_valid && !cmd_ready, the source must hold the command stable.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - A simultaneous push and pop leaves fifo_count unchanged.
  - A pop never occurs when the FIFO is empty.
- FSM states are IDLE and ISSUE.
- IDLE:
  - If fifo_count != 0, pop the head and load op, mask and remaining = (repeat==0 ? 1 : repeat).
  - On that same edge, register j_out/k_out for the popped command and go to ISSUE.
  - If the FIFO is empty, stay in IDLE with j_out=k_out=0.
- ISSUE:
  - Each edge decrements remaining.
  - When remaining==1 at an edge and the FIFO is non-empty, pop the next command and load it. The next command's J/K appear in the very next cycle, with no bubble.
  - When remaining==1 at an edge and the FIFO is empty, go to IDLE and drive j_out=k_out=0.
  - Otherwise hold the same J/K values.
- J/K encoding per bit i:
  - j_out[i] = mask[i] & op[1].
  - k_out[i] = mask[i] & (op==01 | op==11).
  - Hold (00) drives 0/0 for its repeat duration; it is used as a timed gap.
- Latency:
  - A command pushed at edge t with the FIFO empty and the FSM idle pops at edge t+1.
  - j_out/k_out are valid from t+1 to t+1+R.
  - The flop bank samples them at edges t+2 .. t+1+R, where R is the effective repeat.
- Simultaneous push while idle with the FIFO empty: the command is first written to the FIFO and popped on the following edge; there is no bypass path.
- busy=1 exactly in the cycles where ISSUE drives J/K.

Test Plan:
- Reset then idle: hold reset 2 cycles -> j_out=00, k_out=00, busy=0, fifo_count=0, cmd_ready=1.
- Single set: op=10, mask=0x0F, repeat=1 accepted at edge t -> j_out=0x0F and k_out=0x00 for exactly one cycle after t+1, then 0/0; the attached flops read Q[3:0]=1111.
- Toggle train: op=11, mask=0x01, repeat=3 -> j_out=k_out=0x01 for 3 consecutive cycles; busy high for 3 cycles; flop 0 ends inverted from its start value.
- Back-to-back with repeat=0:
  - Push clear (mask 0xFF, repeat 2) then set (mask 0xAA, repeat 0) on consecutive edges.
  - Expected: k_out=0xFF for 2 cycles, then j_out=0xAA for 1 cycle, with no zero gap between them.
- Full/backpressure:
  - Push 5 commands with repeat=4 while the first is issuing; the FIFO holds DEPTH=4.
  - Expected: cmd_ready drops once fifo_count=4, the 5th command is held and accepted after the next pop, and all 5 issue in order.
- Reset mid-operation: assert reset during cycle 2 of a repeat=8 toggle with 2 entries queued -> j_out=k_out=0 next cycle, fifo_count=0, and nothing issues after reset is released.

Source files
------------

// File: rtl/jk_drive_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_drive_sequencer_if
// Description : Command handshake bundle feeding the JK drive sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_drive_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_mask,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_mask,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/jk_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_drive_sequencer
// Description : Buffers hold/clear/set/toggle commands and replays each as
//               registered J/K vectors for its repeat count.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_drive_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    jk_drive_sequencer_if.slave           cmd,
    output logic [WIDTH-1:0]              j_out,
    output logic [WIDTH-1:0]              k_out,
    output logic                          busy,
    output logic [$clog2(DEPTH):0]        fifo_count
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int ENTRY_W = 2 + WIDTH + CNT_W;

    localparam logic [CW-1:0]    c_DEPTH    = CW'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ZERO     = '0;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [CNT_W-1:0]     r_remaining;
    logic [WIDTH-1:0]     r_j;
    logic [WIDTH-1:0]     r_k;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic [ENTRY_W-1:0]   w_head;
    logic [1:0]           w_head_op;
    logic [WIDTH-1:0]     w_head_mask;
    logic [CNT_W-1:0]     w_head_rep;
    logic [CNT_W-1:0]     w_head_rem;
    logic [WIDTH-1:0]     w_head_j;
    logic [WIDTH-1:0]     w_head_k;
    logic [CNT_W-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_j_nxt;
    logic [WIDTH-1:0]     w_k_nxt;

    // Ready depends only on the registered count, so a pop never frees a
    // slot for a push in the same cycle.
    assign w_ready    = (r_count < c_DEPTH);
    assign w_push     = cmd.cmd_valid && w_ready;
    assign w_nonempty = (r_count != '0);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[ENTRY_W-1 -: 2];
    assign w_head_mask = w_head[CNT_W +: WIDTH];
    assign w_head_rep  = w_head[CNT_W-1:0];
    assign w_head_rem  = (w_head_rep == c_ZERO) ? c_ONE : w_head_rep;

    // op[1] selects J (set/toggle), op[0] selects K (clear/toggle).
    assign w_head_j = w_head_mask & {WIDTH{w_head_op[1]}};
    assign w_head_k = w_head_mask & {WIDTH{w_head_op[0]}};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd.cmd_op, cmd.cmd_mask, cmd.cmd_repeat};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_j         <= '0;
            r_k         <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rem_nxt   = r_remaining;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;

        case (r_state)
            S_IDLE: begin
                w_j_nxt = '0;
                w_k_nxt = '0;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_rem_nxt   = w_head_rem;
                    w_j_nxt     = w_head_j;
                    w_k_nxt     = w_head_k;
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (r_remaining == c_ONE) begin
                    // Chain straight into the next command to avoid a bubble.
                    if (w_nonempty) begin
                        w_pop     = 1'b1;
                        w_rem_nxt = w_head_rem;
                        w_j_nxt   = w_head_j;
                        w_k_nxt   = w_head_k;
                    end else begin
                        w_rem_nxt   = '0;
                        w_j_nxt     = '0;
                        w_k_nxt     = '0;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_rem_nxt = r_remaining - c_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
                w_j_nxt     = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    assign cmd.cmd_ready = w_ready;
    assign j_out         = r_j;
    assign k_out         = r_k;
    assign busy          = (r_state == S_ISSUE);
    assign fifo_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_jk_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_drive_sequencer
// Description : Directed bench for jk_drive_sequencer with a JK flop bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_drive_sequencer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] j_out;
    logic [WIDTH-1:0] k_out;
    logic             busy;
    logic [2:0]       fifo_count;
    logic [WIDTH-1:0] q;

    int               n_checks = 0;
    int               n_errors = 0;
    logic             cap_en = 1'b0;
    logic [WIDTH-1:0] trace [$];

    jk_drive_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cmd_if ();

    jk_drive_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_if),
        .j_out      (j_out),
        .k_out      (k_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Downstream JK flop bank: Q+ = J&~Q | ~K&Q.
    always @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= (j_out & ~q) | (~k_out & q);
    end

    always @(posedge clk) begin
        if (cap_en) begin
            #1;
            trace.push_back(j_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [WIDTH-1:0] mask, input logic [CNT_W-1:0] rep);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_op     = op;
        cmd_if.cmd_mask   = mask;
        cmd_if.cmd_repeat = rep;
    endtask

    task automatic idle_bus();
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        int stalls;
        int max_count;
        bit acc;

        reset             = 1'b1;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = 2'b00;
        cmd_if.cmd_mask   = '0;
        cmd_if.cmd_repeat = '0;

        // Reset then idle
        tick();
        tick();
        check("rst_j",     j_out, 8'h00);
        check("rst_k",     k_out, 8'h00);
        check("rst_busy",  busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_ready", cmd_if.cmd_ready, 1'b1);
        reset = 1'b0;
        tick();
        check("idle_j", j_out, 8'h00);

        // Single set, mask 0x0F, repeat 1
        drive(2'b10, 8'h0F, 4'd1);
        tick();
        idle_bus();
        check("set_cnt_t",   fifo_count, 3'd1);
        check("set_j_t",     j_out, 8'h00);
        tick();
        check("set_j",       j_out, 8'h0F);
        check("set_k",       k_out, 8'h00);
        check("set_busy",    busy, 1'b1);
        check("set_cnt",     fifo_count, 3'd0);
        tick();
        check("set_j_after", j_out, 8'h00);
        check("set_busy_after", busy, 1'b0);
        check("set_q",       q, 8'h0F);

        // Toggle train on flop 0, repeat 3
        drive(2'b11, 8'h01, 4'd3);
        tick();
        idle_bus();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("tog_j",    j_out, 8'h01);
            check("tog_k",    k_out, 8'h01);
            check("tog_busy", busy, 1'b1);
        end
        tick();
        check("tog_busy_end", busy, 1'b0);
        check("tog_j_end",    j_out, 8'h00);
        check("tog_q",        q, 8'h0E);

        // Back-to-back: clear FF x2 then set AA with repeat 0
        drive(2'b01, 8'hFF, 4'd2);
        tick();
        drive(2'b10, 8'hAA, 4'd0);
        tick();
        idle_bus();
        check("b2b_k1",  k_out, 8'hFF);
        check("b2b_j1",  j_out, 8'h00);
        check("b2b_cnt", fifo_count, 3'd1);
        tick();
        check("b2b_k2",  k_out, 8'hFF);
        tick();
        check("b2b_j3",  j_out, 8'hAA);
        check("b2b_k3",  k_out, 8'h00);
        check("b2b_busy3", busy, 1'b1);
        tick();
        check("b2b_j4",  j_out, 8'h00);
        check("b2b_busy4", busy, 1'b0);
        check("b2b_q",   q, 8'hAA);

        // Hold as a timed gap
        drive(2'b00, 8'hFF, 4'd2);
        tick();
        idle_bus();
        tick();
        check("hold_busy1", busy, 1'b1);
        check("hold_jk1",   {j_out, k_out}, 16'h0000);
        tick();
        check("hold_busy2", busy, 1'b1);
        tick();
        check("hold_busy3", busy, 1'b0);
        check("hold_q",     q, 8'hAA);

        // Backpressure: one command issuing, five more pushed behind it
        drive(2'b10, 8'h01, 4'd4);
        tick();
        cap_en    = 1'b1;
        stalls    = 0;
        max_count = 0;
        for (int i = 1; i < 6; i++) begin
            drive(2'b10, 8'(1 << i), 4'd4);
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
                if (fifo_count == 3'd4) check("bp_ready_full", cmd_if.cmd_ready, 1'b0);
                if (cmd_if.cmd_ready) acc = 1'b1;
                else                  stalls++;
                tick();
            end
            if (!acc) check("bp_accept_timeout", 0, 1);
        end
        idle_bus();
        for (int w = 0; w < 60 && busy; w++) tick();
        cap_en = 1'b0;
        check("bp_idle",   busy, 1'b0);
        check("bp_stalls", stalls, 1);
        check("bp_peak",   max_count, 4);
        check("bp_len",    trace.size(), 25);
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (4 * i + c < trace.size()) check("bp_order", trace[4 * i + c], 1 << i);
            end
        end
        if (trace.size() > 24) check("bp_tail", trace[24], 8'h00);

        // Reset mid-operation during a repeat-8 toggle with 2 queued
        drive(2'b11, 8'hFF, 4'd8);
        tick();
        drive(2'b10, 8'h0F, 4'd2);
        tick();
        tick();
        idle_bus();
        check("mr_cnt_pre",  fifo_count, 3'd2);
        check("mr_busy_pre", busy, 1'b1);
        check("mr_j_pre",    j_out, 8'hFF);
        reset = 1'b1;
        tick();
        check("mr_jk",    {j_out, k_out}, 16'h0000);
        check("mr_cnt",   fifo_count, 3'd0);
        check("mr_busy",  busy, 1'b0);
        check("mr_ready", cmd_if.cmd_ready, 1'b1);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("mr_post_jk",   {j_out, k_out}, 16'h0000);
            check("mr_post_busy", busy, 1'b0);
        end
        check("mr_post_cnt", fifo_count, 3'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
